// File: rtl/mp3_frame_packer.sv
// MPEG-1 Layer III (44.1 kHz) frame packer: emits a 4-byte header then frame_size-4 payload bytes.
// Optional zero-fill flush port is enabled by defining MP3_PACKER_ZERO_FILL_EN.
module mp3_frame_packer #(
    parameter bit PRIV_BIT      = 1'b0,
    parameter bit COPYRIGHT_BIT = 1'b0,
    parameter bit ORIGINAL_BIT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MP3_PACKER_ZERO_FILL_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [3:0]  bitrate_idx,
    input  logic        padding,
    input  logic        prot,
    input  logic [1:0]  mode,
    input  logic [1:0]  mode_ext,
    input  logic [1:0]  emphasis,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic [10:0] frame_size,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t      state;
    logic [3:0]  idx_q;
    logic        pad_q;
    logic        prot_q;
    logic [1:0]  mode_q;
    logic [1:0]  mode_ext_q;
    logic [1:0]  emph_q;
    logic [10:0] cnt;          // frame index of the next byte to load
    logic        last_loaded;
    logic [10:0] lut_size;
    logic        legal;
    logic        can_load;
    logic        flush_act;
    logic [7:0]  hdr_byte;

    always_comb begin
        lut_size = '0;
        case (bitrate_idx)
            4'd1:    lut_size = 11'd104;
            4'd2:    lut_size = 11'd130;
            4'd3:    lut_size = 11'd156;
            4'd4:    lut_size = 11'd182;
            4'd5:    lut_size = 11'd208;
            4'd6:    lut_size = 11'd261;
            4'd7:    lut_size = 11'd313;
            4'd8:    lut_size = 11'd365;
            4'd9:    lut_size = 11'd417;
            4'd10:   lut_size = 11'd522;
            4'd11:   lut_size = 11'd626;
            4'd12:   lut_size = 11'd731;
            4'd13:   lut_size = 11'd835;
            4'd14:   lut_size = 11'd1044;
            default: lut_size = '0;
        endcase
    end

    always_comb begin
        hdr_byte = 8'hFF;
        case (cnt[1:0])
            2'd1:    hdr_byte = {4'b1111, 1'b1, 2'b01, prot_q};
            2'd2:    hdr_byte = {idx_q, 2'b00, pad_q, PRIV_BIT};
            2'd3:    hdr_byte = {mode_q, mode_ext_q, COPYRIGHT_BIT, ORIGINAL_BIT, emph_q};
            default: hdr_byte = 8'hFF;
        endcase
    end

`ifdef MP3_PACKER_ZERO_FILL_EN
    logic flush_q;
    // Live flush takes effect in the same cycle; the latch keeps it until frame end.
    assign flush_act = (state == PAYLOAD) && (flush_q || flush);
`else
    assign flush_act = 1'b0;
`endif

    assign legal    = (bitrate_idx != 4'd0) && (bitrate_idx != 4'd15);
    assign can_load = !m_valid || m_ready;
    assign s_ready  = (state == PAYLOAD) && can_load && !last_loaded && !flush_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx_q       <= '0;
            pad_q       <= 1'b0;
            prot_q      <= 1'b0;
            mode_q      <= '0;
            mode_ext_q  <= '0;
            emph_q      <= '0;
            cnt         <= '0;
            last_loaded <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            frame_size  <= '0;
            err         <= 1'b0;
`ifdef MP3_PACKER_ZERO_FILL_EN
            flush_q     <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            idx_q       <= bitrate_idx;
                            pad_q       <= padding;
                            prot_q      <= prot;
                            mode_q      <= mode;
                            mode_ext_q  <= mode_ext;
                            emph_q      <= emphasis;
                            frame_size  <= lut_size + {10'd0, padding};
                            busy        <= 1'b1;
                            m_data      <= 8'hFF;
                            m_valid     <= 1'b1;
                            m_last      <= 1'b0;
                            cnt         <= 11'd1;
                            last_loaded <= 1'b0;
`ifdef MP3_PACKER_ZERO_FILL_EN
                            flush_q     <= 1'b0;
`endif
                            state       <= HDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (can_load) begin
                        m_data  <= hdr_byte;
                        m_valid <= 1'b1;
                        cnt     <= cnt + 11'd1;
                        if (cnt == 11'd3) state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
`ifdef MP3_PACKER_ZERO_FILL_EN
                    flush_q <= flush_q | flush;
`endif
                    if (m_valid && m_ready && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (can_load && !last_loaded && (flush_act || s_valid)) begin
                        m_data  <= flush_act ? 8'h00 : s_data;
                        m_valid <= 1'b1;
                        // Counter parks on the final index instead of stepping past it.
                        if (cnt == frame_size - 11'd1) begin
                            m_last      <= 1'b1;
                            last_loaded <= 1'b1;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_frame_packer.sv
// Randomized self-checking bench for mp3_frame_packer against a byte-stream model of each frame.
module tb_mp3_frame_packer;

    localparam int PRIV = 0;
    localparam int CPR  = 0;
    localparam int ORIG = 1;

    logic        clk = 1'b0;
    logic        rst, start, padding, prot;
    logic [3:0]  bitrate_idx;
    logic [1:0]  mode, mode_ext, emphasis;
    logic [7:0]  s_data, m_data;
    logic        s_valid, s_ready, m_valid, m_ready, m_last, busy, err;
    logic [10:0] frame_size;
`ifdef MP3_PACKER_ZERO_FILL_EN
    logic        flush;
`endif

    int tests = 0;
    int fails = 0;

    int         fs_tab [16] = '{0, 104, 130, 156, 182, 208, 261, 313, 365, 417, 522, 626, 731, 835, 1044, 0};
    logic [7:0] src [1100];
    logic [7:0] hdr_seen [4];
    int f_idx, f_pad, f_prot, f_mode, f_mx, f_em, f_flush_at;

    always #5 clk = ~clk;

    mp3_frame_packer #(.PRIV_BIT(1'b0), .COPYRIGHT_BIT(1'b0), .ORIGINAL_BIT(1'b1)) dut (
        .clk(clk), .rst(rst),
`ifdef MP3_PACKER_ZERO_FILL_EN
        .flush(flush),
`endif
        .start(start), .bitrate_idx(bitrate_idx), .padding(padding), .prot(prot),
        .mode(mode), .mode_ext(mode_ext), .emphasis(emphasis),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .frame_size(frame_size), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected byte k of the current frame, from the header bit layout and the source sequence.
    function automatic int model_byte(input int k);
        int p;
        case (k)
            0: return 255;
            1: return 250 + f_prot;
            2: return f_idx * 16 + f_pad * 2 + PRIV;
            3: return f_mode * 64 + f_mx * 16 + CPR * 8 + ORIG * 4 + f_em;
            default: begin
                p = k - 4;
                if (f_flush_at >= 0 && p >= f_flush_at) return 0;
                return int'(src[p]);
            end
        endcase
    endfunction

    task automatic run_frame(input int idx, input int pad, input int pr, input int md, input int mx,
                             input int em, input int rdy_pct, input int val_pct,
                             input int flush_at, input int rst_at);
        int  fs, out_n, ntaken;
        bit  done, prev_stall, first, flush_on;
        logic [7:0] prev_data;
        logic       prev_last;
        fs = fs_tab[idx] + pad;
        f_idx = idx; f_pad = pad; f_prot = pr; f_mode = md; f_mx = mx; f_em = em;
        f_flush_at = flush_at;
        for (int i = 0; i < 1100; i++) src[i] = 8'($urandom);
        out_n = 0; ntaken = 0; done = 0; prev_stall = 0; first = 1; flush_on = 0;
        prev_data = '0; prev_last = 1'b0;
        bitrate_idx = 4'(idx); padding = pad[0]; prot = pr[0];
        mode = 2'(md); mode_ext = 2'(mx); emphasis = 2'(em);
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            if (cyc > 20000) begin
                tests++; fails++;
                $display("FAIL timeout: frame idx %0d stuck after %0d of %0d bytes", idx, out_n, fs);
                break;
            end
            if (done) begin
                chk("end_m_valid", m_valid, 0);
                chk("end_m_last", m_last, 0);
                chk("end_busy", busy, 0);
                chk("end_byte_count", out_n, fs);
                if (flush_at < 0) chk("end_src_reads", ntaken, fs - 4);
                break;
            end
            if (first) begin
                chk("first_m_valid", m_valid, 1);
                chk("first_m_data", m_data, 8'hFF);
                chk("first_busy", busy, 1);
                chk("frame_size", frame_size, fs);
                first = 0;
            end else begin
                chk("busy_in_frame", busy, 1);
            end
            chk("err_in_frame", err, 0);
            if (prev_stall) begin
                chk("stall_m_valid", m_valid, 1);
                chk("stall_m_data", m_data, prev_data);
                chk("stall_m_last", m_last, prev_last);
            end
            if (rst_at >= 0 && out_n == rst_at) begin
                start = 1'b0; rst = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_s_ready", s_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_size", frame_size, 0);
                chk("rst_err", err, 0);
                s_valid = 1'b0;
                @(negedge clk);
                chk("rst_quiet_m_valid", m_valid, 0);
                chk("rst_quiet_m_last", m_last, 0);
                return;
            end
            m_ready = ($urandom % 100) < rdy_pct;
            s_valid = ($urandom % 100) < val_pct;
            s_data  = s_valid ? src[ntaken] : 8'($urandom);
            start   = (out_n < fs / 2) && ($urandom % 8 == 0);
            bitrate_idx = 4'($urandom); padding = 1'($urandom); prot = 1'($urandom);
            mode = 2'($urandom); mode_ext = 2'($urandom); emphasis = 2'($urandom);
`ifdef MP3_PACKER_ZERO_FILL_EN
            if (flush_at >= 0 && ntaken >= flush_at) flush_on = 1;
            flush = flush_on;
`endif
            #1;
            if (flush_on) chk("flush_s_ready", s_ready, 0);
            if (m_valid && m_ready) begin
                if (out_n >= fs) begin
                    tests++; fails++;
                    $display("FAIL extra_byte: got byte %0d, expected only %0d", out_n + 1, fs);
                end else begin
                    chk("m_data", m_data, model_byte(out_n));
                    chk("m_last", m_last, 32'(out_n == fs - 1));
                    if (out_n < 4) hdr_seen[out_n] = m_data;
                end
                if (m_last) done = 1;
                out_n++;
            end
            if (s_valid && s_ready) begin
                if (ntaken >= fs - 4) begin
                    tests++; fails++;
                    $display("FAIL over_read: got read %0d, expected at most %0d", ntaken + 1, fs - 4);
                end
                ntaken++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            @(negedge clk);
        end
        start = 1'b0; s_valid = 1'b0;
`ifdef MP3_PACKER_ZERO_FILL_EN
        flush = 1'b0;
`endif
    endtask

    task automatic bad_start(input logic [3:0] idx, input int held_fs);
        start = 1'b1; bitrate_idx = idx;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_m_valid", m_valid, 0);
        chk("err_busy", busy, 0);
        chk("err_frame_size_held", frame_size, held_fs);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_idle_busy", busy, 0);
        chk("err_idle_m_valid", m_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bitrate_idx = '0; padding = 1'b0; prot = 1'b0;
        mode = '0; mode_ext = '0; emphasis = '0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
`ifdef MP3_PACKER_ZERO_FILL_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_size", frame_size, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(9, 0, 1, 1, 2, 0, 100, 100, -1, -1);
        chk("pin_f1_b0", hdr_seen[0], 8'hFF);
        chk("pin_f1_b1", hdr_seen[1], 8'hFB);
        chk("pin_f1_b2", hdr_seen[2], 8'h90);
        chk("pin_f1_b3", hdr_seen[3], 8'h64);
        // Starts in the same cycle busy fell.
        run_frame(1, 1, 0, 2, 0, 1, 100, 100, -1, -1);
        chk("pin_f2_b1", hdr_seen[1], 8'hFA);
        chk("pin_f2_b2", hdr_seen[2], 8'h12);
        chk("pin_f2_b3", hdr_seen[3], 8'h85);
        chk("pin_f2_size", frame_size, 105);

        bad_start(4'd0, 105);
        bad_start(4'd15, 105);

        for (int n = 0; n < 4; n++)
            run_frame(int'($urandom_range(1, 14)), int'($urandom % 2), int'($urandom % 2),
                      int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                      int'($urandom_range(30, 90)), int'($urandom_range(40, 90)), -1, -1);

        run_frame(3, 0, 1, 0, 0, 0, 70, 80, -1, 54);
        run_frame(2, 1, 1, 3, 1, 2, 60, 70, -1, -1);
`ifdef MP3_PACKER_ZERO_FILL_EN
        run_frame(5, 0, 1, 1, 0, 0, 100, 100, 20, -1);
        run_frame(6, 1, 0, 0, 3, 1, 50, 70, 37, -1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mp3_frame_packer.md
Name: mp3_frame_packer

Overview:
- Transmit-side counterpart of the MPEG-1 Layer III header parser.
- Builds the 4-byte frame header from latched field values.
- Emits the header as a byte stream, followed by exactly (frame_size - 4) payload bytes pulled from an upstream byte source.
- Sits between the side-info/main-data byte producer and the SD/UART byte sink. Assumes Layer III at 44.1 kHz.

Parameters:
- PRIV_BIT, 0: value of header private bit (byte2 bit0).
- COPYRIGHT_BIT, 0: value of header copyright bit (byte3 bit3).
- ORIGINAL_BIT, 1: value of header original bit (byte3 bit2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new frame; sampled only in IDLE.
- bitrate_idx  in  4  header bitrate index; 1..14 legal.
- padding  in  1  padding bit.
- prot  in  1  protection bit (1 = no CRC).
- mode  in  2  channel mode.
- mode_ext  in  2  mode extension.
- emphasis  in  2  emphasis.
- s_data  in  8  payload byte from source.
- s_valid  in  1  payload byte valid.
- s_ready  out  1  packer accepts payload byte.
- m_data  out  8  output byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  sink accepts output byte.
- m_last  out  1  high with final byte of frame.
- busy  out  1  frame in progress.
- frame_size  out  11  latched frame length in bytes.
- err  out  1  one-cycle pulse: start with illegal bitrate_idx.

Behaviour:
- Reset: state IDLE; m_data=0, m_valid=0, m_last=0, s_ready=0, busy=0, frame_size=0, err=0, byte counter=0.
- Reset mid-frame aborts immediately: no m_last, no further bytes.
- Output stage is a single register.
  - m_data/m_valid/m_last are held stable while m_valid && !m_ready.
  - A byte transfers when m_valid && m_ready.
  - The stage may load a new byte in the same cycle the old one transfers.
- States: IDLE, HDR, PAYLOAD.
- IDLE, start=1, bitrate_idx in 1..14:
  - Latch all fields.
  - frame_size = LUT + padding. LUT by index 1..14: 104,130,156,182,208,261,313,365,417,522,626,731,835,1044.
  - busy=1; go to HDR.
  - Next cycle: m_valid=1, m_data=0xFF.
- IDLE, start=1, bitrate_idx 0 or 15: err=1 for one cycle; stay IDLE; frame_size unchanged; no output.
- start while busy: ignored.
- HDR emits 4 bytes, each advancing on transfer:
  - byte0 = 0xFF.
  - byte1 = {1111, 1, 01, prot}.
  - byte2 = {bitrate_idx, 00, padding, PRIV_BIT}.
  - byte3 = {mode, mode_ext, COPYRIGHT_BIT, ORIGINAL_BIT, emphasis}.
- After byte3 is loaded, go to PAYLOAD.
- PAYLOAD:
  - s_ready = (!m_valid || m_ready) && bytes remaining > 0.
  - On s_valid && s_ready, s_data is loaded into the output register and the counter increments.
  - The byte at frame index frame_size-1 is loaded with m_last=1.
  - s_ready drops once that byte is loaded; the source is never over-read.
- On transfer of the m_last byte: m_valid=0 and m_last=0 the next cycle; state IDLE; busy=0.
  - start is accepted in the same cycle busy deasserts (back-to-back frames).
- Counter is 11 bits, counts 0..frame_size-1, no wrap. frame_size stays valid until the next legal start.
- s_valid low in PAYLOAD: m_valid drops after the pending byte transfers; no bubbles are inserted into the byte count.

Optional Feature:
- Macro: MP3_PACKER_ZERO_FILL_EN.
- With the macro: adds input port flush (1 bit).
  - flush=1 in PAYLOAD forces s_ready=0.
  - All remaining payload bytes are emitted as 0x00 at full rate, subject to m_ready, with m_last on the final one.
  - The frame keeps exactly frame_size bytes.
  - flush is ignored in IDLE/HDR and latched until frame end.
- Without the macro: no flush port; payload comes only from s_data.

Test Plan:
- start, idx=9, pad=0, prot=1, mode=01, mode_ext=10, emph=00, m_ready=1, s_valid=1 -> header FF FB 90 64 (ORIGINAL_BIT=1); frame_size=417; 413 payload bytes match s_data; m_last on 417th byte; busy falls after.
- start, idx=1, pad=1, prot=0 -> header FF FA 12 xx; frame_size=105; 101 payload bytes; back-to-back start next cycle is accepted.
- start with idx=0, then idx=15 -> err pulses one cycle each; m_valid stays 0; busy stays 0.
- m_ready toggled pseudo-randomly; s_valid gapped -> m_data stable while stalled; no byte lost or duplicated; total bytes equal frame_size.
- rst asserted at payload byte 50 -> all outputs 0 next cycle; no m_last; new start works normally.
- (MP3_PACKER_ZERO_FILL_EN) idx=5, flush at payload byte 20 -> remaining 184 bytes are 0x00; s_ready stays 0; m_last on byte 208.
